// File: rtl/dmem_pkg.sv
// Shared definitions for the block data memory behind the data cache.
//   ADDR_W / DATA_W : block address and block width
//   DEPTH           : number of blocks
//   LATENCY_DEF     : default number of BUSY cycles per access
//   CNT_W           : width of the latency down-counter (LATENCY up to 15)
//   state_e         : controller states
//   op_e            : latched access type
package dmem_pkg;

  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEPTH       = 1 << ADDR_W;
  localparam int unsigned LATENCY_DEF = 4;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Cache-to-memory block transfer bus.
//   mem_read      : block read request (held until busywait seen low)
//   mem_write     : block write request (held until busywait seen low)
//   mem_address   : block address
//   mem_writedata : block to write
//   mem_readdata  : block read result
//   mem_busywait  : access in progress
// Modports: master = requester (cache), slave = memory.
interface data_memory_ctrl_if;
  import dmem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/dmem_array.sv
// 64 x 32 block storage.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low clear of every block and of the read register
//   we_i    : write enable, wdata_i stored at addr_i on the edge
//   re_i    : read enable, block at addr_i captured into rdata_o on the edge
//   addr_i  : block address
//   wdata_i : block to write
//   rdata_o : registered read data, holds until the next read or clear
module dmem_array
  import dmem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Block data memory controller: serves whole-block refills and write-backs
// from the data cache with a fixed access latency.
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset (aborts any access in flight)
//   bus    : data_memory_ctrl_if.slave (mem_read/mem_write/mem_address/
//            mem_writedata in, mem_readdata/mem_busywait out)
//   LATENCY: BUSY cycles per access, 1..15
// Optional macro DMEM_ACCESS_STATS_EN adds saturating read_count/write_count
// outputs, incremented on entry to DONE for the matching access type.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic        clock,
  input  logic        reset,
  data_memory_ctrl_if.slave bus
`ifdef DMEM_ACCESS_STATS_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  op_e               op_q, op_d;

  logic busy;
  logic arr_we;
  logic arr_re;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    busy    = 1'b0;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = bus.mem_read | bus.mem_write;
        if (busy) begin
          addr_d  = bus.mem_address;
          wdata_d = bus.mem_writedata;
          // A simultaneous read+write request is served as a write.
          op_d    = bus.mem_write ? OP_WRITE : OP_READ;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          arr_we  = (op_q == OP_WRITE);
          arr_re  = (op_q == OP_READ);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // Request still held by the cache on this edge is deliberately
        // ignored so one request is never served twice.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  dmem_array u_array (
    .clk_i   (clock),
    .rst_ni  (reset),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (bus.mem_readdata)
  );

  assign bus.mem_busywait = busy;

`ifdef DMEM_ACCESS_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (arr_re && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (arr_we && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
`endif

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Block-organised data memory: 64 blocks × 32 bits (256 bytes), sitting directly downstream of the data cache.
- Serves whole-block reads (refill) and writes (write-back) over a mem_read/mem_write/busywait handshake.
- Models a fixed multi-cycle access latency.
- Adds a one-cycle completion state so a requester that drops its request only on the edge after busywait falls is never served twice.

Parameters:
- LATENCY, 4, clock cycles in BUSY per access (legal range 1..15)
- ADDR_W, 6, block address width
- DATA_W, 32, block width

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- mem_read  in  1  block read request, held until busywait seen low
- mem_write  in  1  block write request, held until busywait seen low
- mem_address  in  6  block address
- mem_writedata  in  32  block to write
- mem_readdata  out  32  block read result
- mem_busywait  out  1  access in progress

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE, counter=0, mem_readdata=0, all 64 blocks cleared to 0.
  - An access in flight is aborted; no array write occurs.
- States: IDLE, BUSY, DONE.
- IDLE:
  - mem_busywait = mem_read | mem_write, combinationally, same cycle.
  - On a rising edge with a request present: latch address, writedata and op; counter=LATENCY-1; go to BUSY.
- BUSY:
  - mem_busywait=1; inputs ignored, latched copies used.
  - Each edge with counter≠0: decrement.
  - Edge with counter==0: perform the access and go to DONE.
    - Read: mem_readdata ← array[addr].
    - Write: array[addr] ← latched data.
- DONE:
  - mem_busywait=0 regardless of inputs; mem_readdata valid.
  - Next edge: go to IDLE unconditionally; a request present on that edge is NOT sampled.
- Handshake timing: busywait is high for the IDLE request cycle plus exactly LATENCY cycles, then low for exactly one cycle.
  - Back-to-back write-back then refill costs LATENCY+2 cycles each.
- mem_readdata:
  - Registered; changes only on read completion or reset.
  - Holds its value across writes and idle.
- Simultaneous mem_read & mem_write in IDLE: treated as a write; readdata unchanged.
- Request deasserted while in BUSY: access still completes (latched).
- Address is 6-bit; no wrap or out-of-range case exists.

Optional Feature:
- Macro DMEM_ACCESS_STATS_EN.
- Defined:
  - Adds outputs read_count[15:0] and write_count[15:0].
  - Each increments on entry to DONE for its op type.
  - Saturating at 16'hFFFF.
  - Cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE/BUSY/DONE)
  - ADDR_W, DATA_W, default LATENCY
  - counter width constant CNT_W=4
- One natural sub-module: dmem_array.
  - 64×32 storage with synchronous write port, registered read port and asynchronous active-low clear.
  - Controller FSM plus latency counter stay in data_memory_ctrl.

Test Plan:
- Reset low mid-BUSY of write (addr 6'h05, data 32'hDEADBEEF) -> mem_busywait=0 immediately; after release, read 6'h05 returns 32'h00000000.
- Write 6'h0A ← 32'h11223344, LATENCY=4 -> busywait high 5 cycles, low 1 cycle; subsequent read of 6'h0A returns 32'h11223344 in DONE.
- Requester holds mem_read through DONE edge (cache-style) -> exactly one access performed; busywait re-rises only when the request is re-presented after IDLE.
- Write-back 6'h3F ← 32'hCAFEF00D immediately followed by refill read of 6'h1F -> read returns 32'h00000000; array[6'h3F]=32'hCAFEF00D; total 2×(LATENCY+2) cycles.
- mem_read and mem_write both high, addr 6'h02, data 32'hA5A5A5A5 -> write performed; mem_readdata keeps its previous value.
- DMEM_ACCESS_STATS_EN defined: 3 reads, 2 writes -> read_count=3, write_count=2; reset -> both 0.
